// File: rtl/muldiv_unit_pkg.sv
// Shared types and constants for the M-extension multiply/divide unit.
package MULDIV_FNS;

  // Operation select, RISC-V funct3 encoding of the M extension.
  typedef enum logic [2:0] {
    MUL    = 3'b000,
    MULH   = 3'b001,
    MULHSU = 3'b010,
    MULHU  = 3'b011,
    DIV    = 3'b100,
    DIVU   = 3'b101,
    REM    = 3'b110,
    REMU   = 3'b111
  } muldiv_fn_t;

  // Sequencer states of muldiv_unit.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } muldiv_state_t;

  // funct7 value that decode uses to route an R-type op to this unit.
  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

endpackage

// File: rtl/muldiv_unit_prep.sv
// Combinational operand conditioning: magnitudes, result sign, and the
// divide-by-zero / signed-overflow results that need no iteration.
module muldiv_prep
  import MULDIV_FNS::*;
#(
  parameter int WIDTH = 32
) (
  input  muldiv_fn_t       fn_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] a_abs_o,
  output logic [WIDTH-1:0] b_abs_o,
  output logic             neg_res_o,
  output logic             special_o,
  output logic [WIDTH-1:0] special_res_o
);

  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  logic a_signed, b_signed, is_div, is_rem;
  logic a_neg, b_neg, div_zero, ovf;

  // Decode signedness, take magnitudes and detect the non-iterative cases.
  always_comb begin
    a_signed = (fn_i == MULH) || (fn_i == MULHSU) || (fn_i == DIV) || (fn_i == REM);
    b_signed = (fn_i == MULH) || (fn_i == DIV) || (fn_i == REM);
    is_div   = fn_i[2];
    is_rem   = fn_i[2] & fn_i[1];
    a_neg    = a_signed & a_i[WIDTH-1];
    b_neg    = b_signed & b_i[WIDTH-1];
    // The most negative value negates to itself, which is its correct
    // unsigned magnitude.
    a_abs_o  = a_neg ? -a_i : a_i;
    b_abs_o  = b_neg ? -b_i : b_i;
    // Remainder follows the dividend; product and quotient follow the xor.
    neg_res_o = is_rem ? a_neg : (a_neg ^ b_neg);
    div_zero  = is_div & (b_i == '0);
    ovf       = is_div & b_signed & (a_i == MIN_NEG) & (b_i == '1);
    special_o = div_zero | ovf;
    special_res_o = '0;
    if (div_zero) begin
      special_res_o = is_rem ? a_i : '1;
    end else if (ovf) begin
      special_res_o = is_rem ? '0 : a_i;
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M/RV64M multiply/divide unit with valid/ready on both sides.
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high; ready never depends on valid, valid never depends on ready.
module muldiv_unit
  import MULDIV_FNS::*;
#(
  parameter int WIDTH = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       fn,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  muldiv_state_t      state_q, state_d;
  muldiv_fn_t         fn_q, fn_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [TAG_W-1:0]   tag_q, tag_d;
  logic [WIDTH-1:0]   op_q, op_d;        // multiplicand or divisor
  logic [2*WIDTH-1:0] acc_q, acc_d;      // {partial/remainder, multiplier/quotient}
  logic               neg_q, neg_d;
  logic               special_q, special_d;
  logic [WIDTH-1:0]   out_q, out_d;

  logic [WIDTH-1:0] p_a_abs, p_b_abs, p_special_res;
  logic             p_neg, p_special;

  muldiv_prep #(.WIDTH(WIDTH)) u_prep (
    .fn_i          (muldiv_fn_t'(fn)),
    .a_i           (a),
    .b_i           (b),
    .a_abs_o       (p_a_abs),
    .b_abs_o       (p_b_abs),
    .neg_res_o     (p_neg),
    .special_o     (p_special),
    .special_res_o (p_special_res)
  );

  logic [WIDTH-1:0]   hi, lo, div_sub, fix_res;
  logic [WIDTH:0]     mul_sum, div_shift;
  logic               div_ge;
  logic [2*WIDTH-1:0] mul_next, div_next, prod;

  // One shift-add or restoring-divide step, plus the final sign/half select.
  always_comb begin
    hi        = acc_q[2*WIDTH-1:WIDTH];
    lo        = acc_q[WIDTH-1:0];
    mul_sum   = {1'b0, hi} + (lo[0] ? {1'b0, op_q} : '0);
    mul_next  = {mul_sum, lo[WIDTH-1:1]};
    div_shift = {hi, lo[WIDTH-1]};
    div_ge    = div_shift >= {1'b0, op_q};
    div_sub   = div_shift[WIDTH-1:0] - op_q;
    div_next  = {(div_ge ? div_sub : div_shift[WIDTH-1:0]), lo[WIDTH-2:0], div_ge};
    prod      = neg_q ? -acc_q : acc_q;
    fix_res   = '0;
    if (special_q) begin
      fix_res = lo;
    end else begin
      case (fn_q)
        MUL:                  fix_res = prod[WIDTH-1:0];
        MULH, MULHSU, MULHU:  fix_res = prod[2*WIDTH-1:WIDTH];
        DIV, DIVU:            fix_res = neg_q ? -lo : lo;
        default:              fix_res = neg_q ? -hi : hi;
      endcase
    end
  end

  // Next-state and register-update logic; flush overrides everything.
  always_comb begin
    state_d   = state_q;
    fn_d      = fn_q;
    cnt_d     = cnt_q;
    tag_d     = tag_q;
    op_d      = op_q;
    acc_d     = acc_q;
    neg_d     = neg_q;
    special_d = special_q;
    out_d     = out_q;
    if (flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            fn_d      = muldiv_fn_t'(fn);
            tag_d     = in_tag;
            cnt_d     = '0;
            neg_d     = p_neg;
            special_d = p_special;
            if (p_special) begin
              // Special result parks in the accumulator and is registered
              // by FIX, giving a one-cycle result with no iteration.
              op_d    = '0;
              acc_d   = {{WIDTH{1'b0}}, p_special_res};
              state_d = FIX;
            end else begin
              op_d    = fn[2] ? p_b_abs : p_a_abs;
              acc_d   = {{WIDTH{1'b0}}, (fn[2] ? p_a_abs : p_b_abs)};
              state_d = CALC;
            end
          end
        end
        CALC: begin
          acc_d = fn_q[2] ? div_next : mul_next;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_LAST) begin
            state_d = FIX;
          end
        end
        FIX: begin
          out_d   = fix_res;
          state_d = DONE;
        end
        default: begin
          if (out_ready) begin
            state_d = IDLE;
          end
        end
      endcase
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      fn_q      <= MUL;
      cnt_q     <= '0;
      tag_q     <= '0;
      op_q      <= '0;
      acc_q     <= '0;
      neg_q     <= 1'b0;
      special_q <= 1'b0;
      out_q     <= '0;
    end else begin
      state_q   <= state_d;
      fn_q      <= fn_d;
      cnt_q     <= cnt_d;
      tag_q     <= tag_d;
      op_q      <= op_d;
      acc_q     <= acc_d;
      neg_q     <= neg_d;
      special_q <= special_d;
      out_q     <= out_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign out_valid = (state_q == DONE);
  assign out       = out_q;
  assign out_tag   = tag_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit at WIDTH=32 with hand-computed results.
module tb_muldiv_unit;
  import MULDIV_FNS::*;

  localparam int W  = 32;
  localparam int TW = 5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b0;
  logic [2:0]    fn = 3'b000;
  logic [W-1:0]  a = '0;
  logic [W-1:0]  b = '0;
  logic [TW-1:0] in_tag = '0;
  logic          in_ready, out_valid, busy;
  logic [W-1:0]  out;
  logic [TW-1:0] out_tag;

  muldiv_unit #(.WIDTH(W), .TAG_W(TW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .fn        (fn),
    .a         (a),
    .b         (b),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out),
    .out_tag   (out_tag),
    .busy      (busy)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Scoreboard
  int n_tests = 0;
  int n_fail  = 0;
  logic [W-1:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Driver tasks; all assume entry #1 after a rising edge.
  task automatic send(input logic [2:0] f, input logic [W-1:0] ia, input logic [W-1:0] ib,
                      input logic [TW-1:0] t);
    in_valid = 1'b1;
    fn       = f;
    a        = ia;
    b        = ib;
    in_tag   = t;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_result(input string name, input logic [TW-1:0] t, input int exp_lat);
    int lat = 0;
    logic [W-1:0] e;
    while (!out_valid && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check({name, "_lat"}, 64'(lat), 64'(exp_lat));
    e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
    check({name, "_out"}, 64'(out), 64'(e));
    check({name, "_tag"}, 64'(out_tag), 64'(t));
  endtask

  task automatic handshake(input string name);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check({name, "_ov_fall"}, 64'(out_valid), 64'd0);
    check({name, "_rdy_rise"}, 64'(in_ready), 64'd1);
  endtask

  task automatic run_op(input string name, input logic [2:0] f, input logic [W-1:0] ia,
                        input logic [W-1:0] ib, input logic [TW-1:0] t,
                        input logic [W-1:0] exp, input int exp_lat);
    check({name, "_idle"}, 64'(in_ready), 64'd1);
    exp_q.push_back(exp);
    send(f, ia, ib, t);
    wait_result(name, t, exp_lat);
    handshake(name);
  endtask

  // Main sequence
  initial begin
    int seen;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_out", 64'(out), 64'd0);
    check("rst_out_tag", 64'(out_tag), 64'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Arithmetic vectors
    run_op("mul",    MUL,    32'd7,        32'hFFFFFFFD, 5'd3,  32'hFFFFFFEB, 33);
    run_op("mulh",   MULH,   32'h80000000, 32'h80000000, 5'd4,  32'h40000000, 33);
    run_op("mulhu",  MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 5'd5,  32'hFFFFFFFE, 33);
    run_op("mulhsu", MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd6,  32'hFFFFFFFF, 33);
    run_op("div",    DIV,    32'hFFFFFFF9, 32'd2,        5'd7,  32'hFFFFFFFD, 33);
    run_op("rem",    REM,    32'hFFFFFFF9, 32'd2,        5'd8,  32'hFFFFFFFF, 33);
    run_op("divu",   DIVU,   32'hFFFFFFFE, 32'd2,        5'd9,  32'h7FFFFFFF, 33);
    run_op("remu",   REMU,   32'd7,        32'd3,        5'd10, 32'd1,        33);

    // Special cases
    run_op("div0",   DIV,    32'd5,        32'd0,        5'd11, 32'hFFFFFFFF, 1);
    run_op("rem0",   REM,    32'd5,        32'd0,        5'd12, 32'd5,        1);
    run_op("divu0",  DIVU,   32'd5,        32'd0,        5'd13, 32'hFFFFFFFF, 1);
    run_op("remu0",  REMU,   32'd5,        32'd0,        5'd14, 32'd5,        1);
    run_op("divovf", DIV,    32'h80000000, 32'hFFFFFFFF, 5'd15, 32'h80000000, 1);
    run_op("removf", REM,    32'h80000000, 32'hFFFFFFFF, 5'd16, 32'd0,        1);

    // Backpressure: result held while out_ready stays low
    exp_q.push_back(32'd14);
    send(DIVU, 32'd100, 32'd7, 5'd17);
    wait_result("bp", 5'd17, 33);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check("bp_hold_valid", 64'(out_valid), 64'd1);
      check("bp_hold_out", 64'(out), 64'd14);
      check("bp_hold_tag", 64'(out_tag), 64'd17);
      check("bp_hold_in_ready", 64'(in_ready), 64'd0);
    end
    // New request already presented on the handshake edge must wait one cycle
    out_ready = 1'b1;
    in_valid  = 1'b1;
    fn        = REMU;
    a         = 32'd100;
    b         = 32'd7;
    in_tag    = 5'd18;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("bp_rel_in_ready", 64'(in_ready), 64'd1);
    check("bp_rel_busy", 64'(busy), 64'd0);
    check("bp_rel_out_valid", 64'(out_valid), 64'd0);
    exp_q.push_back(32'd2);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("bp_next_accept", 64'(busy), 64'd1);
    wait_result("bp_next", 5'd18, 33);
    handshake("bp_next");

    // Flush mid-CALC
    send(MUL, 32'd12345, 32'd678, 5'd19);
    repeat (9) @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    check("flush_busy", 64'(busy), 64'd0);
    check("flush_in_ready", 64'(in_ready), 64'd1);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) seen = 1;
    end
    check("flush_no_valid", 64'(seen), 64'd0);
    // A request presented together with flush is dropped
    in_valid = 1'b1;
    flush    = 1'b1;
    fn       = MUL;
    a        = 32'd3;
    b        = 32'd3;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    flush    = 1'b0;
    check("flush_req_dropped", 64'(busy), 64'd0);
    run_op("post_flush", MUL, 32'd12345, 32'd678, 5'd20, 32'd8369910, 33);

    // Asynchronous reset mid-CALC
    send(MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd21);
    repeat (5) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_in_ready", 64'(in_ready), 64'd1);
    check("arst_out_valid", 64'(out_valid), 64'd0);
    check("arst_busy", 64'(busy), 64'd0);
    check("arst_out", 64'(out), 64'd0);
    check("arst_out_tag", 64'(out_tag), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    run_op("post_rst_div", DIV, 32'd100, 32'hFFFFFFF9, 5'd22, 32'hFFFFFFF2, 33);
    run_op("post_rst_rem", REM, 32'd100, 32'hFFFFFFF9, 5'd23, 32'd2,        33);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
